// File: rtl/fxdiv_seq.sv
// Sequential signed fixed-point divider (restoring radix-2, one quotient bit per clock).
// Build option FXDIV_SAT_EN: saturate the quotient on overflow instead of wrapping.
module fxdiv_seq #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DECIMAL_BITS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot_out,
    output logic             div0_out,
    output logic             ovf_out
);

    localparam int unsigned NumBits = WIDTH + DECIMAL_BITS;
    localparam int unsigned CntW    = $clog2(NumBits);

    localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MaxNeg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic               sign_q;
    logic [WIDTH-1:0]   b_mag_q;
    logic [WIDTH-1:0]   rem_q;
    logic [NumBits-1:0] num_q;
    logic [NumBits-2:0] q_q;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_diff;
    logic [WIDTH-1:0]   rem_next;
    logic               rem_ge;
    logic [NumBits-1:0] q_next;
    logic [NumBits-1:0] ovf_lim;
    logic               ovf_next;
    logic [WIDTH-1:0]   quot_wrap;
    logic [WIDTH-1:0]   quot_next;

    // Unsigned magnitudes; the most negative value maps onto 2^(WIDTH-1) exactly.
    always_comb begin
        a_abs = a_in[WIDTH-1] ? -a_in : a_in;
        b_abs = b_in[WIDTH-1] ? -b_in : b_in;
    end

    always_comb begin
        rem_shift = {rem_q, num_q[NumBits-1]};
        rem_ge    = rem_shift >= {1'b0, b_mag_q};
        rem_diff  = rem_shift[WIDTH-1:0] - b_mag_q;
        rem_next  = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
        q_next    = {q_q, rem_ge};

        // A negative result may reach magnitude 2^(WIDTH-1), a positive one only 2^(WIDTH-1)-1.
        ovf_lim   = sign_q ? NumBits'(MaxNeg) : NumBits'(MaxPos);
        ovf_next  = q_next > ovf_lim;
        quot_wrap = sign_q ? -q_next[WIDTH-1:0] : q_next[WIDTH-1:0];
`ifdef FXDIV_SAT_EN
        quot_next = ovf_next ? (sign_q ? MaxNeg : MaxPos) : quot_wrap;
`else
        quot_next = quot_wrap;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            b_mag_q   <= '0;
            rem_q     <= '0;
            num_q     <= '0;
            q_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quot_out  <= '0;
            div0_out  <= 1'b0;
            ovf_out   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sign_q   <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        b_mag_q  <= b_abs;
                        rem_q    <= '0;
                        num_q    <= NumBits'(a_abs) << DECIMAL_BITS;
                        q_q      <= '0;
                        in_ready <= 1'b0;
                        if (b_in == '0) begin
                            state_q   <= StDone;
                            out_valid <= 1'b1;
                            div0_out  <= 1'b1;
                            ovf_out   <= 1'b0;
                            quot_out  <= a_in[WIDTH-1] ? MaxNeg : MaxPos;
                        end else begin
                            state_q <= StDiv;
                            cnt_q   <= CntW'(NumBits - 1);
                        end
                    end
                end
                StDiv: begin
                    rem_q <= rem_next;
                    num_q <= {num_q[NumBits-2:0], 1'b0};
                    q_q   <= q_next[NumBits-2:0];
                    if (cnt_q == '0) begin
                        state_q   <= StDone;
                        out_valid <= 1'b1;
                        quot_out  <= quot_next;
                        div0_out  <= 1'b0;
                        ovf_out   <= ovf_next;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fxdiv_seq.sv
// Directed bench for fxdiv_seq: vector table plus backpressure and mid-division reset sequences.
module tb_fxdiv_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quot_out;
    logic        div0_out;
    logic        ovf_out;

    int tests = 0;
    int fails = 0;

    fxdiv_seq #(.WIDTH(32), .DECIMAL_BITS(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot_out  (quot_out),
        .div0_out  (div0_out),
        .ovf_out   (ovf_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        d0;
        logic        ov;
        int          lat;
    } vec_t;

`ifdef FXDIV_SAT_EN
    localparam logic [31:0] OvfPos  = 32'h7FFFFFFF;
    localparam logic [31:0] OvfPos2 = 32'h7FFFFFFF;
    localparam logic [31:0] OvfNeg  = 32'h80000000;
`else
    localparam logic [31:0] OvfPos  = 32'h80000000;
    localparam logic [31:0] OvfPos2 = 32'hFFFFFFFE;
    localparam logic [31:0] OvfNeg  = 32'h00000000;
`endif

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Enters and leaves aligned 1 time unit after a rising edge.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, output logic [31:0] q,
                          output logic d0, output logic ov, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        q  = quot_out;
        d0 = div0_out;
        ov = ovf_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q;
        logic        d0, ov;
        int          lat;
        int          seen;

        vecs[0]  = '{32'h00030000, 32'h00020000, 32'h00018000, 1'b0, 1'b0, 49};
        vecs[1]  = '{32'hFFFF0000, 32'h00030000, 32'hFFFFAAAB, 1'b0, 1'b0, 49};
        vecs[2]  = '{32'h00010000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
        vecs[3]  = '{32'hFFFF0000, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 1};
        vecs[4]  = '{32'h40000000, 32'h00008000, OvfPos,       1'b0, 1'b1, 49};
        vecs[5]  = '{32'h80000000, 32'hFFFF0000, OvfPos,       1'b0, 1'b1, 49};
        vecs[6]  = '{32'hFFFD0000, 32'hFFFE0000, 32'h00018000, 1'b0, 1'b0, 49};
        vecs[7]  = '{32'h00010000, 32'hFFFF8000, 32'hFFFE0000, 1'b0, 1'b0, 49};
        vecs[8]  = '{32'h00000000, 32'h00050000, 32'h00000000, 1'b0, 1'b0, 49};
        vecs[9]  = '{32'hFFFFFFFF, 32'h00020000, 32'h00000000, 1'b0, 1'b0, 49};
        vecs[10] = '{32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 1'b0, 49};
        vecs[11] = '{32'h7FFFFFFF, 32'h00010000, 32'h7FFFFFFF, 1'b0, 1'b0, 49};
        vecs[12] = '{32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
        vecs[13] = '{32'h00000001, 32'h00000003, 32'h00005555, 1'b0, 1'b0, 49};
        vecs[14] = '{32'h7FFFFFFF, 32'h00008000, OvfPos2,      1'b0, 1'b1, 49};
        vecs[15] = '{32'h80000000, 32'h00008000, OvfNeg,       1'b0, 1'b1, 49};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset quot", quot_out, 32'h0);
        check("reset div0", 32'(div0_out), 32'd0);
        check("reset ovf", 32'(ovf_out), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            do_div(vecs[i].a, vecs[i].b, q, d0, ov, lat);
            check($sformatf("vec%0d quot", i), q, vecs[i].q);
            check($sformatf("vec%0d div0", i), 32'(d0), 32'(vecs[i].d0));
            check($sformatf("vec%0d ovf", i), 32'(ov), 32'(vecs[i].ov));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure: result held while out_ready is low, new requests ignored.
        a_in     = 32'h00030000;
        b_in     = 32'h00020000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp latency", 32'(lat), 32'd49);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                a_in     = 32'h00050000;
                b_in     = 32'h00010000;
                in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check($sformatf("bp%0d quot", k), quot_out, 32'h00018000);
            check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d flags", k), {30'd0, div0_out, ovf_out}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp post out_valid", 32'(out_valid), 32'd0);
        check("bp post in_ready", 32'(in_ready), 32'd1);
        check("bp post quot hold", quot_out, 32'h00018000);
        repeat (3) @(posedge clk);
        #1;
        check("bp idle out_valid", 32'(out_valid), 32'd0);
        check("bp idle in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset in the middle of a division.
        a_in     = 32'h00030000;
        b_in     = 32'h00020000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst quot", quot_out, 32'h0);
        check("rst flags", {30'd0, div0_out, ovf_out}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rst no out_valid", 32'(seen), 32'd0);
        do_div(32'h00050000, 32'h00010000, q, d0, ov, lat);
        check("post-rst quot", q, 32'h00050000);
        check("post-rst flags", {30'd0, d0, ov}, 32'd0);
        check("post-rst latency", 32'(lat), 32'd49);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
